// File: rtl/memory_access_lat_pkg.sv
// memory_access_lat_pkg
// Shared Y86-64 instruction/status/register codes used by the memory-access
// stage, the FSM state type and helpers that classify an instruction's memory
// behaviour. No ports.
package memory_access_lat_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_kind_e;

    function automatic acc_kind_e acc_kind(input logic [3:0] icode);
        case (icode)
            IRMMOVQ, IPUSHQ, ICALL: acc_kind = ACC_WRITE;
            IMRMOVQ, IPOPQ, IRET:   acc_kind = ACC_READ;
            default:                acc_kind = ACC_NONE;
        endcase
    endfunction

    // pop and ret read from the stack pointer carried on valA
    function automatic logic addr_from_vala(input logic [3:0] icode);
        return (icode == IPOPQ) || (icode == IRET);
    endfunction

endpackage

// File: rtl/memory_access_lat_if.sv
// memory_access_lat_if
// Stage-boundary bundle between execute/pipeline control and the memory-access
// stage. master: upstream driver (drives *_i, observes *_o).
// slave: the memory-access stage (observes *_i, drives *_o).
//   stall_i, bubble_i          pipeline control
//   icode_i..cnd_i             execute-stage results
//   icode_o..cnd_o, M_valA_o   registered stage outputs
//   busy_o, dmem_error_o       access in flight / memory fault
interface memory_access_lat_if;

    logic        stall_i;
    logic        bubble_i;
    logic [3:0]  icode_i;
    logic [2:0]  stat_i;
    logic [63:0] valA_i;
    logic [63:0] valE_i;
    logic [3:0]  dstE_i;
    logic [3:0]  dstM_i;
    logic        cnd_i;

    logic [3:0]  icode_o;
    logic [2:0]  stat_o;
    logic [63:0] valE_o;
    logic [63:0] valM_o;
    logic [3:0]  dstE_o;
    logic [3:0]  dstM_o;
    logic [63:0] M_valA_o;
    logic        cnd_o;
    logic        busy_o;
    logic        dmem_error_o;

    modport master (
        output stall_i, bubble_i, icode_i, stat_i, valA_i, valE_i, dstE_i, dstM_i, cnd_i,
        input  icode_o, stat_o, valE_o, valM_o, dstE_o, dstM_o, M_valA_o, cnd_o,
               busy_o, dmem_error_o
    );

    modport slave (
        input  stall_i, bubble_i, icode_i, stat_i, valA_i, valE_i, dstE_i, dstM_i, cnd_i,
        output icode_o, stat_o, valE_o, valM_o, dstE_o, dstM_o, M_valA_o, cnd_o,
               busy_o, dmem_error_o
    );

endinterface

// File: rtl/memory_access_lat_dmem_bank.sv
// dmem_bank
// Byte-addressed data memory with one synchronous 8-byte little-endian write
// port and one combinational 8-byte read port. Every byte is set to INIT_BYTE
// while rst_i is high.
//   clk_i, rst_i  clock, synchronous active-high reset
//   we            write enable
//   addr          byte address of lane 0
//   wdata         write data, lane k = wdata[8k+7:8k]
//   rdata         read data, same lane mapping
module dmem_bank #(
    parameter int         DEPTH_BYTES = 1024,
    parameter logic [7:0] INIT_BYTE   = 8'h10
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           we,
    input  logic [$clog2(DEPTH_BYTES)-1:0] addr,
    input  logic [63:0]                    wdata,
    output logic [63:0]                    rdata
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic [7:0] mem [DEPTH_BYTES];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem[i] <= INIT_BYTE;
            end
        end else if (we) begin
            for (int k = 0; k < 8; k++) begin
                mem[addr + AW'(k)] <= wdata[8*k +: 8];
            end
        end
    end

    // Lane addresses wrap within AW bits; the caller masks out-of-range reads.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < 8; k++) begin
            rdata[8*k +: 8] = mem[addr + AW'(k)];
        end
    end

endmodule

// File: rtl/memory_access_lat.sv
// memory_access_lat
// Y86-64 memory-access stage with configurable access latency. Holds the
// stage register, range check, latency FSM/counter and the data memory bank.
//   clk_i, rst_i  clock, synchronous active-high reset
//   bus (slave)   stage inputs/outputs, busy_o and dmem_error_o
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | stage accepts/stalls/bubbles; WAIT_CYC=0 accesses commit here
// WAIT    | memory access in flight, busy_o=1, counter runs down to 1
module memory_access_lat
    import memory_access_lat_pkg::*;
#(
    parameter int         DEPTH_BYTES = 1024,
    parameter int         WAIT_CYC    = 0,
    parameter logic [7:0] INIT_BYTE   = 8'h10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    memory_access_lat_if.slave bus
);

    localparam int          AW        = $clog2(DEPTH_BYTES);
    localparam logic [63:0] ADDR_MAX  = 64'(DEPTH_BYTES - 8);
    localparam logic [2:0]  WAIT_LOAD = 3'(WAIT_CYC);

    mem_state_e  state_q, state_d;
    logic [2:0]  cnt_q;

    logic [3:0]  icode_q, dstE_q, dstM_q;
    logic [2:0]  stat_q;
    logic [63:0] valE_q, valA_q, valM_q;
    logic        cnd_q, err_q;

    logic [3:0]  src_icode;
    logic [2:0]  src_stat;
    logic [63:0] src_valA, src_valE, addr;
    acc_kind_e   kind;
    logic        range_err, access_ok, capture, go_wait;
    logic        busy, commit, mem_we;
    logic [63:0] rdata, mem_val;

    // In IDLE the access is evaluated on the live inputs (zero-wait commit);
    // in WAIT it is evaluated on the captured instruction.
    always_comb begin
        src_icode = (state_q == ST_WAIT) ? icode_q : bus.icode_i;
        src_stat  = (state_q == ST_WAIT) ? stat_q  : bus.stat_i;
        src_valA  = (state_q == ST_WAIT) ? valA_q  : bus.valA_i;
        src_valE  = (state_q == ST_WAIT) ? valE_q  : bus.valE_i;
        kind      = acc_kind(src_icode);
        addr      = addr_from_vala(src_icode) ? src_valA : src_valE;
        // full 64-bit compare so huge addresses cannot alias into range
        range_err = (kind != ACC_NONE) && (src_stat == SAOK) && (addr > ADDR_MAX);
        access_ok = (kind != ACC_NONE) && (src_stat == SAOK) && !range_err;
        mem_val   = (access_ok && (kind == ACC_READ)) ? rdata : '0;
        capture   = (state_q == ST_IDLE) && !bus.bubble_i && !bus.stall_i;
        go_wait   = capture && (kind != ACC_NONE) && (WAIT_CYC != 0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (go_wait) begin
                cnt_q <= WAIT_LOAD;
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (go_wait) state_d = ST_WAIT;
            ST_WAIT: if (bus.bubble_i || (cnt_q == 3'd1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == ST_WAIT);
        commit = 1'b0;
        if (state_q == ST_IDLE) begin
            commit = capture && (WAIT_CYC == 0);
        end else begin
            commit = !bus.bubble_i && (cnt_q == 3'd1);
        end
        mem_we = commit && access_ok && (kind == ACC_WRITE) && !rst_i;
    end

    // Bubble loads NOP in either state; in WAIT it also abandons the access.
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.bubble_i) begin
            icode_q <= INOP;
            stat_q  <= SAOK;
            valE_q  <= '0;
            valA_q  <= '0;
            valM_q  <= '0;
            dstE_q  <= RNONE;
            dstM_q  <= RNONE;
            cnd_q   <= 1'b0;
            err_q   <= 1'b0;
        end else if (capture) begin
            icode_q <= bus.icode_i;
            stat_q  <= bus.stat_i;
            valE_q  <= bus.valE_i;
            valA_q  <= bus.valA_i;
            dstE_q  <= bus.dstE_i;
            dstM_q  <= bus.dstM_i;
            cnd_q   <= bus.cnd_i;
            if (go_wait) begin
                err_q <= 1'b0;
            end else begin
                valM_q <= mem_val;
                err_q  <= range_err;
            end
        end else if (commit) begin
            valM_q <= mem_val;
            err_q  <= range_err;
        end
    end

    dmem_bank #(
        .DEPTH_BYTES(DEPTH_BYTES),
        .INIT_BYTE  (INIT_BYTE)
    ) u_bank (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .we   (mem_we),
        .addr (addr[AW-1:0]),
        .wdata(src_valA),
        .rdata(rdata)
    );

    always_comb begin
        if ((stat_q == SINS) || (stat_q == SADR) || (stat_q == SHLT)) begin
            bus.stat_o = stat_q;
        end else if (err_q) begin
            bus.stat_o = SADR;
        end else begin
            bus.stat_o = SAOK;
        end
    end

    assign bus.icode_o      = icode_q;
    assign bus.valE_o       = valE_q;
    assign bus.valM_o       = valM_q;
    assign bus.dstE_o       = dstE_q;
    assign bus.dstM_o       = dstM_q;
    assign bus.M_valA_o     = valA_q;
    assign bus.cnd_o        = cnd_q;
    assign bus.busy_o       = busy;
    assign bus.dmem_error_o = err_q;

endmodule

// File: tb/tb_memory_access_lat.sv
// tb_memory_access_lat
// Two stage instances share clock and reset: dut0 with WAIT_CYC=0 and dut3
// with WAIT_CYC=3. Each issued instruction pushes its expected result into a
// scoreboard queue; the entry is popped and compared once the stage commits.
module tb_memory_access_lat;
    import memory_access_lat_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    memory_access_lat_if if0 ();
    memory_access_lat_if if3 ();

    memory_access_lat #(.DEPTH_BYTES(1024), .WAIT_CYC(0), .INIT_BYTE(8'h10)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(if0)
    );
    memory_access_lat #(.DEPTH_BYTES(1024), .WAIT_CYC(3), .INIT_BYTE(8'h10)) dut3 (
        .clk_i(clk), .rst_i(rst), .bus(if3)
    );

    typedef struct {
        string       tag;
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] valE;
        logic [63:0] valA;
        logic [63:0] valM;
        logic        err;
        logic        cnd;
    } exp_t;

    typedef struct packed {
        logic [3:0]  icode;
        logic [2:0]  stat;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [63:0] valA;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic        cnd;
        logic        busy;
        logic        err;
    } obs_t;

    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t obs(input int sel);
        obs_t o;
        if (sel == 0) begin
            o = '{if0.icode_o, if0.stat_o, if0.valE_o, if0.valM_o, if0.M_valA_o,
                  if0.dstE_o, if0.dstM_o, if0.cnd_o, if0.busy_o, if0.dmem_error_o};
        end else begin
            o = '{if3.icode_o, if3.stat_o, if3.valE_o, if3.valM_o, if3.M_valA_o,
                  if3.dstE_o, if3.dstM_o, if3.cnd_o, if3.busy_o, if3.dmem_error_o};
        end
        return o;
    endfunction

    task automatic drive(input int sel, input logic stall, input logic bubble,
                         input logic [3:0] icode, input logic [2:0] stat,
                         input logic [63:0] val_a, input logic [63:0] val_e, input logic cnd);
        if (sel == 0) begin
            if0.stall_i = stall; if0.bubble_i = bubble; if0.icode_i = icode;
            if0.stat_i  = stat;  if0.valA_i   = val_a;  if0.valE_i  = val_e;
            if0.dstE_i  = 4'h3;  if0.dstM_i   = 4'h4;   if0.cnd_i   = cnd;
        end else begin
            if3.stall_i = stall; if3.bubble_i = bubble; if3.icode_i = icode;
            if3.stat_i  = stat;  if3.valA_i   = val_a;  if3.valE_i  = val_e;
            if3.dstE_i  = 4'h3;  if3.dstM_i   = 4'h4;   if3.cnd_i   = cnd;
        end
    endtask

    task automatic set_nop(input int sel);
        drive(sel, 1'b0, 1'b0, INOP, SAOK, '0, '0, 1'b0);
    endtask

    // Called just after a negedge; returns at the negedge where the result is valid.
    task automatic issue(input int sel, input string tag, input logic [3:0] icode,
                         input logic [2:0] stat, input logic [63:0] val_a,
                         input logic [63:0] val_e, input logic cnd,
                         input logic [63:0] exp_valm, input logic [2:0] exp_stat,
                         input logic exp_err, input int exp_busy,
                         input bit stall_busy, input int peek_addr);
        exp_t e;
        obs_t o;
        int   busy_cnt;
        drive(sel, 1'b0, 1'b0, icode, stat, val_a, val_e, cnd);
        e.tag = tag; e.icode = icode; e.stat = exp_stat; e.valE = val_e;
        e.valA = val_a; e.valM = exp_valm; e.err = exp_err; e.cnd = cnd;
        sb_q.push_back(e);
        @(posedge clk);
        #1 set_nop(sel);
        busy_cnt = 0;
        o = obs(sel);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            o = obs(sel);
            if (!o.busy) break;
            busy_cnt++;
            chk({tag, "_hold_icode"}, 64'(o.icode), 64'(icode));
            if (stall_busy) begin
                if (sel == 0) if0.stall_i = 1'b1; else if3.stall_i = 1'b1;
            end
            if (peek_addr >= 0) begin
                chk({tag, "_no_early_write"}, 64'(dut3.u_bank.mem[peek_addr]), 64'h10);
            end
        end
        if (stall_busy) set_nop(sel);
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        e = sb_q.pop_front();
        chk({e.tag, "_icode"}, 64'(o.icode), 64'(e.icode));
        chk({e.tag, "_stat"},  64'(o.stat),  64'(e.stat));
        chk({e.tag, "_valM"},  o.valM,       e.valM);
        chk({e.tag, "_err"},   64'(o.err),   64'(e.err));
        chk({e.tag, "_valE"},  o.valE,       e.valE);
        chk({e.tag, "_valA"},  o.valA,       e.valA);
        chk({e.tag, "_dstE"},  64'(o.dstE),  64'h3);
        chk({e.tag, "_cnd"},   64'(o.cnd),   64'(e.cnd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t o;
        set_nop(0);
        set_nop(1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int s = 0; s < 2; s++) begin
            o = obs(s);
            chk($sformatf("rst%0d_icode", s), 64'(o.icode), 64'(INOP));
            chk($sformatf("rst%0d_stat", s),  64'(o.stat),  64'(SAOK));
            chk($sformatf("rst%0d_busy", s),  64'(o.busy),  64'd0);
            chk($sformatf("rst%0d_err", s),   64'(o.err),   64'd0);
            chk($sformatf("rst%0d_dstM", s),  64'(o.dstM),  64'(RNONE));
        end

        // single-cycle instance
        issue(0, "rd0_init", IMRMOVQ, SAOK, 64'd0, 64'd0, 1'b0,
              64'h1010101010101010, SAOK, 1'b0, 0, 1'b0, -1);
        issue(0, "wr16", IRMMOVQ, SAOK, 64'h0123456789ABCDEF, 64'd16, 1'b0,
              64'd0, SAOK, 1'b0, 0, 1'b0, -1);
        issue(0, "rd16", IMRMOVQ, SAOK, 64'd0, 64'd16, 1'b0,
              64'h0123456789ABCDEF, SAOK, 1'b0, 0, 1'b0, -1);
        chk("byte16", 64'(dut0.u_bank.mem[16]), 64'hEF);
        issue(0, "rd17_lanes", IMRMOVQ, SAOK, 64'd0, 64'd17, 1'b0,
              64'h100123456789ABCD, SAOK, 1'b0, 0, 1'b0, -1);
        issue(0, "rd9_lanes", IMRMOVQ, SAOK, 64'd0, 64'd9, 1'b0,
              64'hEF10101010101010, SAOK, 1'b0, 0, 1'b0, -1);
        issue(0, "rd1016_edge", IMRMOVQ, SAOK, 64'd0, 64'd1016, 1'b0,
              64'h1010101010101010, SAOK, 1'b0, 0, 1'b0, -1);
        issue(0, "wr1017_oor", IRMMOVQ, SAOK, 64'hFFFFFFFFFFFFFFFF, 64'd1017, 1'b0,
              64'd0, SADR, 1'b1, 0, 1'b0, -1);
        issue(0, "rd1016_after", IMRMOVQ, SAOK, 64'd0, 64'd1016, 1'b0,
              64'h1010101010101010, SAOK, 1'b0, 0, 1'b0, -1);
        issue(0, "pop_huge", IPOPQ, SAOK, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0,
              64'd0, SADR, 1'b1, 0, 1'b0, -1);
        issue(0, "pop16_vala", IPOPQ, SAOK, 64'd16, 64'd1000, 1'b0,
              64'h0123456789ABCDEF, SAOK, 1'b0, 0, 1'b0, -1);
        issue(0, "ret24", IRET, SAOK, 64'd24, 64'd16, 1'b0,
              64'h1010101010101010, SAOK, 1'b0, 0, 1'b0, -1);
        issue(0, "wr40_sins", IRMMOVQ, SINS, 64'hAAAAAAAAAAAAAAAA, 64'd40, 1'b0,
              64'd0, SINS, 1'b0, 0, 1'b0, -1);
        issue(0, "rd40_after", IMRMOVQ, SAOK, 64'd0, 64'd40, 1'b0,
              64'h1010101010101010, SAOK, 1'b0, 0, 1'b0, -1);
        issue(0, "opq", IOPQ, SAOK, 64'd5, 64'd1234, 1'b1,
              64'd0, SAOK, 1'b0, 0, 1'b0, -1);

        drive(0, 1'b1, 1'b0, IRRMOVQ, SAOK, 64'd7, 64'h99, 1'b0);
        @(posedge clk);
        @(negedge clk);
        o = obs(0);
        chk("stall_hold_icode", 64'(o.icode), 64'(IOPQ));
        chk("stall_hold_valE",  o.valE,       64'd1234);
        drive(0, 1'b1, 1'b1, IRRMOVQ, SAOK, 64'd7, 64'h99, 1'b1);
        @(posedge clk);
        @(negedge clk);
        o = obs(0);
        chk("bubble_wins_icode", 64'(o.icode), 64'(INOP));
        chk("bubble_wins_dstE",  64'(o.dstE),  64'(RNONE));
        chk("bubble_wins_valE",  o.valE,       64'd0);
        chk("bubble_wins_cnd",   64'(o.cnd),   64'd0);
        set_nop(0);

        // three-wait-cycle instance
        issue(1, "push8_lat", IPUSHQ, SAOK, 64'hCAFEF00D12345678, 64'd8, 1'b0,
              64'd0, SAOK, 1'b0, 3, 1'b1, 8);
        chk("push8_byte8", 64'(dut3.u_bank.mem[8]), 64'h78);
        issue(1, "rd8_lat", IMRMOVQ, SAOK, 64'd0, 64'd8, 1'b0,
              64'hCAFEF00D12345678, SAOK, 1'b0, 3, 1'b0, -1);
        issue(1, "wr1017_lat", IRMMOVQ, SAOK, 64'd1, 64'd1017, 1'b0,
              64'd0, SADR, 1'b1, 3, 1'b0, -1);

        drive(1, 1'b0, 1'b0, IRMMOVQ, SAOK, 64'h5555555555555555, 64'd32, 1'b0);
        @(posedge clk);
        #1 set_nop(1);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_bub_busy_pre", 64'(if3.busy_o), 64'd1);
        drive(1, 1'b0, 1'b1, INOP, SAOK, '0, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_bub_busy",  64'(if3.busy_o),  64'd0);
        chk("abort_bub_icode", 64'(if3.icode_o), 64'(INOP));
        chk("abort_bub_byte32", 64'(dut3.u_bank.mem[32]), 64'h10);
        set_nop(1);
        issue(1, "abort_bub_rd32", IMRMOVQ, SAOK, 64'd0, 64'd32, 1'b0,
              64'h1010101010101010, SAOK, 1'b0, 3, 1'b0, -1);

        drive(1, 1'b0, 1'b0, IRMMOVQ, SAOK, 64'h7777777777777777, 64'd32, 1'b0);
        @(posedge clk);
        #1 set_nop(1);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_rst_busy_pre", 64'(if3.busy_o), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_rst_busy",  64'(if3.busy_o),  64'd0);
        chk("abort_rst_icode", 64'(if3.icode_o), 64'(INOP));
        issue(1, "abort_rst_rd32", IMRMOVQ, SAOK, 64'd0, 64'd32, 1'b0,
              64'h1010101010101010, SAOK, 1'b0, 3, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
